// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: control sequencer for one 8-point 1-D DCT pass.
// For each coefficient u it clears the MAC, streams the 8 products
// {u,x}, waits MAC_LAT cycles for the pipeline to drain, then presents
// the result with a ready/valid handshake. All outputs are registered
// from the next-state values, so they line up with the state they describe.
module dct_mac_sequencer #(
  parameter int MAC_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       res_ready,
  output logic       busy,
  output logic       mac_clr,
  output logic       mac_ena,
  output logic [5:0] mac_idx,
  output logic [2:0] sample_sel,
  output logic       res_valid,
  output logic [2:0] res_idx,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Last value of the drain counter before the result is ready.
  localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

  state_t     state, state_n;
  logic [2:0] u, x, d;
  logic [2:0] u_n, x_n, d_n;
  logic       done_n;

  // Next-state and counter logic; abort overrides every state.
  always_comb begin
    state_n = state;
    u_n     = u;
    x_n     = x;
    d_n     = d;
    done_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
      u_n     = 3'd0;
      x_n     = 3'd0;
      d_n     = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = CLR;
            u_n     = 3'd0;
            x_n     = 3'd0;
            d_n     = 3'd0;
          end
        end
        CLR: begin
          state_n = ACC;
          x_n     = 3'd0;
        end
        ACC: begin
          if (x == 3'd7) begin
            state_n = DRAIN;
            x_n     = 3'd0;
            d_n     = 3'd0;
          end else begin
            x_n = x + 3'd1;
          end
        end
        DRAIN: begin
          if (d == DRAIN_LAST) begin
            state_n = OUT;
            d_n     = 3'd0;
          end else begin
            d_n = d + 3'd1;
          end
        end
        OUT: begin
          if (res_ready) begin
            if (u == 3'd7) begin
              state_n = IDLE;
              u_n     = 3'd0;
              done_n  = 1'b1;
            end else begin
              state_n = CLR;
              u_n     = u + 3'd1;
              x_n     = 3'd0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          u_n     = 3'd0;
          x_n     = 3'd0;
          d_n     = 3'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      u          <= 3'd0;
      x          <= 3'd0;
      d          <= 3'd0;
      busy       <= 1'b0;
      mac_clr    <= 1'b0;
      mac_ena    <= 1'b0;
      mac_idx    <= 6'd0;
      sample_sel <= 3'd0;
      res_valid  <= 1'b0;
      res_idx    <= 3'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      u          <= u_n;
      x          <= x_n;
      d          <= d_n;
      busy       <= (state_n != IDLE);
      mac_clr    <= (state_n == CLR);
      mac_ena    <= (state_n == ACC);
      mac_idx    <= (state_n == ACC) ? {u_n, x_n} : 6'd0;
      sample_sel <= (state_n == ACC) ? x_n : 3'd0;
      res_valid  <= (state_n == OUT);
      res_idx    <= (state_n == OUT) ? u_n : 3'd0;
      done       <= done_n;
    end
  end

endmodule
